adc_sample_ctrl: RTL and testbench
==================================

# adc_sample_ctrl

Downstream consumer of the ADC channel counter on the DE-10 Lite shield path. Watches the counter's channel number, issues one conversion request per channel change to the on-chip ADC command/response interface, and low-pass filters each returned 12-bit sample into a per-channel register. It then derives debounced joystick directions and button states for the game controller logic.

## Interface
- DATA_W, 12: ADC sample width.
- TIMEOUT, 63: max cycles waiting for a response before abort.
- THR_LO, 1024: joystick low threshold (left/up).
- THR_HI, 3072: joystick high threshold (right/down).
- HYST, 128: hysteresis band for all comparisons.
- BTN_THR, 1024: button pressed when filtered value < BTN_THR.

- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- channel_i  in  5  current channel from the counter, valid range 1–5.
- cmd_valid_o  out  1  conversion request valid.
- cmd_channel_o  out  5  channel to convert.
- cmd_ready_i  in  1  ADC accepts request when high with cmd_valid_o.
- rsp_valid_i  in  1  single-cycle response strobe.
- rsp_channel_i  in  5  channel of response.
- rsp_data_i  in  DATA_W  conversion result.
- avg_o  out  5×DATA_W  filtered value per channel (index 0 = channel 1).
- dir_o  out  4  {down, up, right, left}.
- btn_o  out  3  buttons from channels 3–5.
- err_o  out  1  one-cycle pulse on timeout or channel mismatch.

## Operation
- Channel map: 1 = joystick X, 2 = joystick Y, 3–5 = buttons.
- FSM states: IDLE, CMD, WAIT_RSP.
  - IDLE → CMD when channel_i is in 1–5 and differs from last_ch. Latch channel_i into cmd_channel_o.
  - CMD: hold cmd_valid_o = 1 until cmd_ready_i; on handshake → WAIT_RSP and clear the timeout counter.
  - WAIT_RSP, response with rsp_channel_i == cmd_channel_o: update the filter, set last_ch = cmd_channel_o → IDLE.
  - WAIT_RSP, response with mismatched channel: discard, pulse err_o, → IDLE. last_ch is unchanged, so the request retries.
  - WAIT_RSP, counter reaches TIMEOUT: pulse err_o, → IDLE, last_ch unchanged.
- Invalid channel_i (0 or >5): ignored in IDLE.
- Channel changes during CMD/WAIT_RSP are not tracked; the current transaction completes, then IDLE re-evaluates.
- Filter: avg += (sample − avg) >>> 2. Uses 13-bit signed difference with an arithmetic shift. The result always stays within 0..4095, so no saturation is needed.
- Direction hysteresis, X with left/right:
  - left sets when avg < THR_LO and clears when avg ≥ THR_LO+HYST.
  - right sets when avg > THR_HI and clears when avg ≤ THR_HI−HYST.
  - Y uses the same rules for up/down.
- Buttons: pressed sets when avg < BTN_THR and clears when avg ≥ BTN_THR+HYST.
- Left and right can never both be set, since the thresholds are disjoint; the same holds for up/down.

## Timing
- Reset values:
  - state = IDLE, last_ch = 0, cmd_valid_o = 0, cmd_channel_o = 0, err_o = 0.
  - all avg_o = 12'h800.
  - dir_o = 0, btn_o = 0.
- Channel change on channel_i is sampled at edge N; cmd_valid_o is high from N+1.
- cmd_valid_o stays high, with cmd_channel_o stable, until the handshake edge. It falls in the cycle after the handshake.
- rsp_valid_i accepted at edge M: avg_o updates at M+1, dir_o/btn_o update at M+2 (registered compare).
- Response arriving in the same cycle as the timeout expiry: the response wins.
- rsp_valid_i outside WAIT_RSP is ignored, with no err_o.
- Reset mid-transaction: immediately returns to reset values and drops cmd_valid_o asynchronously.
- Minimum loop: 3 cycles per sample (CMD with immediate ready, one WAIT_RSP, IDLE). This fits inside the counter's 11-cycle channel period when ADC latency ≤ 7.

## Structure
- Package adc_pkg:
  - DATA_W.
  - channel constants CH_JOY_X = 1, CH_JOY_Y = 2, CH_BTN0..2 = 3..5.
  - NUM_CH = 5.
  - state enum {IDLE, CMD, WAIT_RSP}.
  - dir bit indices.
- Sub-module hyst_cmp: one registered hysteresis comparator (set threshold, clear threshold, polarity parameter). There are seven instances: 4 directions and 3 buttons.

## Test plan
- Reset, then channel_i = 1 with ready high and rsp (ch 1, data 0) after 2 cycles: cmd_channel_o = 1, avg_o[0] = 0x800 → 0x600.
- Repeated ch 1 samples of 0: avg_o[0] = 0x600, 0x480, 0x360 (below THR_LO). left sets 1 cycle after that update; samples of 4095 then raise avg until ≥ 1152, and left clears.
- Hold cmd_ready_i low for 5 cycles: cmd_valid_o stays high with cmd_channel_o constant, and no second request is issued.
- No response for 63 cycles after handshake: err_o pulses once and state returns to IDLE. A request for the same channel reissues on the next cycle.
- Response with rsp_channel_i = 2 while awaiting 1: err_o pulses, avg_o is unchanged, and channel 1 is retried.
- channel_i = 0 or 6: cmd_valid_o never asserts. Assert reset_ni = 0 during WAIT_RSP: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample controller: channel map,
// direction bit positions, FSM states and the one-pole filter step.
package adc_pkg;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 5;

    localparam int CH_JOY_X = 1;
    localparam int CH_JOY_Y = 2;
    localparam int CH_BTN0  = 3;
    localparam int CH_BTN1  = 4;
    localparam int CH_BTN2  = 5;

    localparam int DIR_LEFT  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;

    localparam logic [DATA_W-1:0] AVG_RST = DATA_W'(1 << (DATA_W - 1));

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    function automatic logic ch_valid(input logic [CH_W-1:0] ch);
        return (ch >= CH_W'(CH_JOY_X)) && (ch <= CH_W'(CH_BTN2));
    endfunction

    // avg + (sample - avg)/4 with floor rounding; result cannot leave 0..4095
    function automatic logic [DATA_W-1:0] filt_step(input logic [DATA_W-1:0] avg,
                                                    input logic [DATA_W-1:0] sample);
        logic signed [DATA_W:0] diff;
        logic signed [DATA_W:0] sum;
        diff = $signed({1'b0, sample}) - $signed({1'b0, avg});
        sum  = $signed({1'b0, avg}) + (diff >>> 2);
        return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/hyst_cmp.sv
// Registered hysteresis comparator. LOW_ACTIVE=1 flags small values
// (set below SET_THR, clear at/above CLR_THR); LOW_ACTIVE=0 mirrors that for large values.
module hyst_cmp
    import adc_pkg::*;
#(
    parameter logic [DATA_W-1:0] SET_THR    = '0,
    parameter logic [DATA_W-1:0] CLR_THR    = '0,
    parameter bit                LOW_ACTIVE = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [DATA_W-1:0] i_val,
    output logic              o_flag
);

    logic r_flag;
    logic w_set;
    logic w_clr;

    assign w_set = LOW_ACTIVE ? (i_val <  SET_THR) : (i_val >  SET_THR);
    assign w_clr = LOW_ACTIVE ? (i_val >= CLR_THR) : (i_val <= CLR_THR);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_flag <= 1'b0;
        end else if (r_flag) begin
            r_flag <= !w_clr;
        end else begin
            r_flag <= w_set;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Requests one ADC conversion per channel change, filters each returned sample
// per channel and derives joystick directions and button states from the averages.
//   state    | meaning
//   IDLE     | wait for a valid channel different from the last one sampled
//   CMD      | cmd_valid_o high until the ADC takes the request
//   WAIT_RSP | wait for the response, abort on wrong channel or timeout
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int THR_LO  = 1024,
    parameter int THR_HI  = 3072,
    parameter int HYST    = 128,
    parameter int BTN_THR = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [CH_W-1:0]                channel_i,
    output logic                           cmd_valid_o,
    output logic [CH_W-1:0]                cmd_channel_o,
    input  logic                           cmd_ready_i,
    input  logic                           rsp_valid_i,
    input  logic [CH_W-1:0]                rsp_channel_i,
    input  logic [DATA_W-1:0]              rsp_data_i,
    output logic [NUM_CH-1:0][DATA_W-1:0]  avg_o,
    output logic [3:0]                     dir_o,
    output logic [2:0]                     btn_o,
    output logic                           err_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                          r_state;
    state_t                          w_next;
    logic                            w_start;
    logic                            w_hs;
    logic                            w_accept;
    logic                            w_fault;
    logic [CH_W-1:0]                 r_last_ch;
    logic [CH_W-1:0]                 r_cmd_ch;
    logic [TMR_W-1:0]                r_tmr;
    logic                            r_err;
    logic [NUM_CH-1:0][DATA_W-1:0]   r_avg;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_hs        = 1'b0;
        w_accept    = 1'b0;
        w_fault     = 1'b0;
        cmd_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (ch_valid(channel_i) && (channel_i != r_last_ch)) begin
                    w_start = 1'b1;
                    w_next  = CMD;
                end
            end
            CMD: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) begin
                    w_hs   = 1'b1;
                    w_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // a response on the expiry edge still counts
                if (rsp_valid_i) begin
                    w_accept = (rsp_channel_i == r_cmd_ch);
                    w_fault  = (rsp_channel_i != r_cmd_ch);
                    w_next   = IDLE;
                end else if (r_tmr == '0) begin
                    w_fault = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_last_ch <= '0;
            r_cmd_ch  <= '0;
            r_tmr     <= '0;
            r_err     <= 1'b0;
            r_avg     <= {NUM_CH{AVG_RST}};
        end else begin
            r_err <= w_fault;
            if (w_start) begin
                r_cmd_ch <= channel_i;
            end
            if (w_hs) begin
                r_tmr <= TMR_W'(TIMEOUT - 1);
            end else if ((r_state == WAIT_RSP) && (r_tmr != '0)) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (w_accept) begin
                r_last_ch <= r_cmd_ch;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept && (r_cmd_ch == CH_W'(i + 1))) begin
                    r_avg[i] <= filt_step(r_avg[i], rsp_data_i);
                end
            end
        end
    end

    assign cmd_channel_o = r_cmd_ch;
    assign err_o         = r_err;
    assign avg_o         = r_avg;

    hyst_cmp #(
        .SET_THR   (DATA_W'(THR_LO)),
        .CLR_THR   (DATA_W'(THR_LO + HYST)),
        .LOW_ACTIVE(1'b1)
    ) u_left (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .i_val   (r_avg[CH_JOY_X-1]),
        .o_flag  (dir_o[DIR_LEFT])
    );

    hyst_cmp #(
        .SET_THR   (DATA_W'(THR_HI)),
        .CLR_THR   (DATA_W'(THR_HI - HYST)),
        .LOW_ACTIVE(1'b0)
    ) u_right (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .i_val   (r_avg[CH_JOY_X-1]),
        .o_flag  (dir_o[DIR_RIGHT])
    );

    hyst_cmp #(
        .SET_THR   (DATA_W'(THR_LO)),
        .CLR_THR   (DATA_W'(THR_LO + HYST)),
        .LOW_ACTIVE(1'b1)
    ) u_up (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .i_val   (r_avg[CH_JOY_Y-1]),
        .o_flag  (dir_o[DIR_UP])
    );

    hyst_cmp #(
        .SET_THR   (DATA_W'(THR_HI)),
        .CLR_THR   (DATA_W'(THR_HI - HYST)),
        .LOW_ACTIVE(1'b0)
    ) u_down (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .i_val   (r_avg[CH_JOY_Y-1]),
        .o_flag  (dir_o[DIR_DOWN])
    );

    for (genvar g = 0; g < 3; g++) begin : g_btn
        hyst_cmp #(
            .SET_THR   (DATA_W'(BTN_THR)),
            .CLR_THR   (DATA_W'(BTN_THR + HYST)),
            .LOW_ACTIVE(1'b1)
        ) u_btn (
            .clk_i   (clk_i),
            .reset_ni(reset_ni),
            .i_val   (r_avg[CH_BTN0-1+g]),
            .o_flag  (btn_o[g])
        );
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Randomized bench for adc_sample_ctrl: acts as the ADC responder and compares
// the averages and flags against a transaction-level reference model.
module tb_adc_sample_ctrl;
    import adc_pkg::*;

    localparam int TIMEOUT = 63;
    localparam int THR_LO  = 1024;
    localparam int THR_HI  = 3072;
    localparam int HYST    = 128;
    localparam int BTN_THR = 1024;

    logic                          clk_i = 1'b0;
    logic                          reset_ni = 1'b0;
    logic [CH_W-1:0]               channel_i = '0;
    logic                          cmd_valid_o;
    logic [CH_W-1:0]               cmd_channel_o;
    logic                          cmd_ready_i = 1'b0;
    logic                          rsp_valid_i = 1'b0;
    logic [CH_W-1:0]               rsp_channel_i = '0;
    logic [DATA_W-1:0]             rsp_data_i = '0;
    logic [NUM_CH-1:0][DATA_W-1:0] avg_o;
    logic [3:0]                    dir_o;
    logic [2:0]                    btn_o;
    logic                          err_o;

    always #5 clk_i = ~clk_i;

    adc_sample_ctrl #(
        .TIMEOUT(TIMEOUT), .THR_LO(THR_LO), .THR_HI(THR_HI), .HYST(HYST), .BTN_THR(BTN_THR)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .channel_i    (channel_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_channel_o(cmd_channel_o),
        .cmd_ready_i  (cmd_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_channel_i(rsp_channel_i),
        .rsp_data_i   (rsp_data_i),
        .avg_o        (avg_o),
        .dir_o        (dir_o),
        .btn_o        (btn_o),
        .err_o        (err_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_avg [NUM_CH];
    bit m_left, m_right, m_up, m_down;
    bit m_btn [3];
    int m_last;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int exp_dir();
        return int'({m_down, m_up, m_right, m_left});
    endfunction

    function automatic int exp_btn();
        return int'({m_btn[2], m_btn[1], m_btn[0]});
    endfunction

    function automatic int rnd_data();
        case ($urandom % 3)
            0:       return 0;
            1:       return 4095;
            default: return int'($urandom % 4096);
        endcase
    endfunction

    function automatic int pick_ch();
        int c;
        do c = int'($urandom_range(1, 5)); while (c == m_last);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_avg[i] = 2048;
        m_left = 0; m_right = 0; m_up = 0; m_down = 0;
        for (int i = 0; i < 3; i++) m_btn[i] = 0;
        m_last = 0;
    endtask

    // quarter of the error, rounded toward minus infinity, then threshold rules
    task automatic model_sample(input int ch, input int data);
        int d;
        d = data - m_avg[ch-1];
        m_avg[ch-1] += (d >= 0) ? d / 4 : -((-d + 3) / 4);
        m_last = ch;
        m_left  = m_left  ? (m_avg[0] < THR_LO + HYST) : (m_avg[0] < THR_LO);
        m_right = m_right ? (m_avg[0] > THR_HI - HYST) : (m_avg[0] > THR_HI);
        m_up    = m_up    ? (m_avg[1] < THR_LO + HYST) : (m_avg[1] < THR_LO);
        m_down  = m_down  ? (m_avg[1] > THR_HI - HYST) : (m_avg[1] > THR_HI);
        for (int i = 0; i < 3; i++)
            m_btn[i] = m_btn[i] ? (m_avg[2+i] < BTN_THR + HYST) : (m_avg[2+i] < BTN_THR);
    endtask

    task automatic check_avg(input string tag);
        for (int i = 0; i < NUM_CH; i++) chk(tag, int'(avg_o[i]), m_avg[i]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, int'(cmd_valid_o), 0);
        chk({tag, "_ch"},    int'(cmd_channel_o), 0);
        chk({tag, "_err"},   int'(err_o), 0);
        chk({tag, "_dir"},   int'(dir_o), 0);
        chk({tag, "_btn"},   int'(btn_o), 0);
        for (int i = 0; i < NUM_CH; i++) chk({tag, "_avg"}, int'(avg_o[i]), 2048);
    endtask

    task automatic wait_cmd(input int ch);
        int k;
        k = 0;
        while (!cmd_valid_o && k < 20) begin
            step();
            k++;
        end
        chk("cmd_wait", int'(cmd_valid_o), 1);
        chk("cmd_ch", int'(cmd_channel_o), ch);
    endtask

    // ready held low for rdy_dly cycles with stray responses that must be ignored
    task automatic do_hs(input int ch, input int rdy_dly);
        for (int i = 0; i < rdy_dly; i++) begin
            cmd_ready_i   = 1'b0;
            rsp_valid_i   = 1'($urandom % 2);
            rsp_channel_i = CH_W'(ch);
            rsp_data_i    = DATA_W'($urandom % 4096);
            step();
            chk("hold_valid", int'(cmd_valid_o), 1);
            chk("hold_ch", int'(cmd_channel_o), ch);
            chk("hold_err", int'(err_o), 0);
        end
        rsp_valid_i = 1'b0;
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        chk("cmd_fall", int'(cmd_valid_o), 0);
    endtask

    // mode 0: clean; 1: wrong-channel response first; 2: timeout first
    task automatic txn(input int ch, input int data, input int rdy_dly, input int lat,
                       input int mode, input int nxt);
        int od, ob, k;
        if (int'(channel_i) != ch) begin
            channel_i = CH_W'(ch);
            step();
            chk("cmd_rise", int'(cmd_valid_o), 1);
            chk("cmd_ch", int'(cmd_channel_o), ch);
        end else begin
            wait_cmd(ch);
        end
        if (mode == 1) begin
            do_hs(ch, rdy_dly);
            repeat (lat) step();
            rsp_valid_i   = 1'b1;
            rsp_channel_i = CH_W'(ch % 5 + 1);
            rsp_data_i    = DATA_W'($urandom % 4096);
            step();
            rsp_valid_i = 1'b0;
            chk("mis_err", int'(err_o), 1);
            check_avg("mis_avg");
            step();
            chk("mis_pulse", int'(err_o), 0);
            chk("mis_retry", int'(cmd_valid_o), 1);
            chk("mis_retry_ch", int'(cmd_channel_o), ch);
        end else if (mode == 2) begin
            do_hs(ch, rdy_dly);
            k = 0;
            do begin
                step();
                k++;
            end while (!err_o && k < 100);
            chk("tmo_cycles", k, TIMEOUT);
            check_avg("tmo_avg");
            step();
            chk("tmo_pulse", int'(err_o), 0);
            chk("tmo_retry", int'(cmd_valid_o), 1);
            chk("tmo_retry_ch", int'(cmd_channel_o), ch);
        end
        do_hs(ch, rdy_dly);
        if (nxt != 0) channel_i = CH_W'(nxt);
        repeat (lat) step();
        rsp_valid_i   = 1'b1;
        rsp_channel_i = CH_W'(ch);
        rsp_data_i    = DATA_W'(data);
        od = exp_dir();
        ob = exp_btn();
        model_sample(ch, data);
        step();
        rsp_valid_i = 1'b0;
        chk("rsp_err", int'(err_o), 0);
        check_avg("avg");
        chk("dir_hold", int'(dir_o), od);
        chk("btn_hold", int'(btn_o), ob);
        step();
        chk("dir", int'(dir_o), exp_dir());
        chk("btn", int'(btn_o), exp_btn());
    endtask

    task automatic bad_ch();
        int vals [4];
        vals[0] = 0; vals[1] = 6; vals[2] = 31; vals[3] = int'($urandom_range(7, 30));
        for (int i = 0; i < 4; i++) begin
            channel_i = CH_W'(vals[i]);
            repeat (3) begin
                step();
                chk("bad_ch", int'(cmd_valid_o), 0);
            end
        end
    endtask

    initial begin
        int ch, nxt, mode, r;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_reset("rst");
        reset_ni = 1'b1;
        step();

        txn(1, 0, 0, 1, 0, 0);
        chk("tp_avg_600", int'(avg_o[0]), 'h600);
        txn(2, 2048, 0, 0, 0, 0);
        txn(1, 0, 1, 0, 0, 0);
        chk("tp_avg_480", int'(avg_o[0]), 'h480);
        txn(2, 2048, 0, 2, 0, 0);
        txn(1, 0, 0, 0, 0, 0);
        chk("tp_avg_360", int'(avg_o[0]), 'h360);
        chk("tp_left_set", int'(dir_o[0]), 1);
        for (int i = 0; i < 4; i++) begin
            txn(2, rnd_data(), 0, 0, 0, 0);
            txn(1, 4095, 0, 1, 0, 0);
        end
        chk("tp_left_clr", int'(dir_o[0]), 0);
        txn(2, 0, 5, 0, 0, 0);
        txn(1, rnd_data(), 0, 0, 2, 0);
        txn(2, rnd_data(), 0, 1, 1, 0);
        txn(1, rnd_data(), 0, 62, 0, 0);
        bad_ch();

        ch = pick_ch();
        nxt = 0;
        for (int it = 0; it < 80; it++) begin
            if (nxt == 0 && it % 20 == 10) bad_ch();
            r = int'($urandom % 10);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            nxt = ($urandom % 3 == 0) ? 1 : 0;
            if (nxt != 0) begin
                do nxt = int'($urandom_range(1, 5)); while (nxt == ch);
            end
            txn(ch, rnd_data(), int'($urandom % 4), int'($urandom % 7), mode, nxt);
            ch = (nxt != 0) ? nxt : pick_ch();
        end

        channel_i = '0;
        repeat (2) step();
        channel_i = CH_W'(pick_ch());
        step();
        chk("rst_cmd_pre", int'(cmd_valid_o), 1);
        #3 reset_ni = 1'b0;
        #1;
        model_reset();
        check_reset("rst_cmd");
        channel_i = '0;
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step();

        channel_i = CH_W'(3);
        step();
        cmd_ready_i = 1'b1;
        step();
        cmd_ready_i = 1'b0;
        step();
        #3 reset_ni = 1'b0;
        #1;
        check_reset("rst_wait");
        channel_i = '0;
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step();
        txn(4, 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
